control_unit: RTL and testbench

Control unit of the single-cycle RV32I processor (top-level instance `cu`). Holds the program counter, decodes the current 32-bit instruction into datapath control signals and a sign-extended immediate, and resolves branches and jumps into the next PC. It sits between instruction memory, the register file, the ALU and data memory; all decode is combinational and only the PC is registered.

---
 rtl/cu_pkg.sv | 51 +++++
 rtl/control_unit_imm_gen.sv | 20 ++
 rtl/control_unit.sv | 171 +++++++++++++++++
 tb/tb_control_unit.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared definitions for the RV32I control unit: opcodes, ALU operation codes,
// write-back select encodings and the reset PC.
package cu_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_e;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  // funct7[5] selects SUB only for register-register ops; SRA for both forms.
  function automatic alu_op_e alu_from_funct(input logic [2:0] funct3,
                                             input logic       alt,
                                             input logic       is_r);
    case (funct3)
      3'd0:    return (alt && is_r) ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return alt ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/control_unit_imm_gen.sv
// Immediate generator: picks the RV32I immediate format from the opcode and
// sign-extends from instruction bit 31.
module imm_gen
  import cu_pkg::*;
(
  input  logic [31:0] instr,
  output logic [31:0] imm
);

  always_comb begin
    case (instr[6:0])
      OP_STORE:        imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OP_BRANCH:       imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      OP_LUI, OP_AUIPC: imm = {instr[31:12], 12'h000};
      OP_JAL:          imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default:         imm = {{20{instr[31]}}, instr[31:20]};
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Single-cycle RV32I control unit: PC register, main decoder, branch resolution.
// Optional macro CU_ILLEGAL_EN flags undecodable instructions and halts the PC.
module control_unit
  import cu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [31:0] alu_result,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] imm,
  output logic [3:0]  alu_op,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic [1:0]  wb_sel,
  output logic        branch_taken,
  output logic        illegal
);

  logic [31:0] pc_q, pc_d;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  alu_op_e     alu_op_d;
  logic        a_sel_d, b_sel_d, rw_d, mr_d, mw_d, legal_d;
  logic        is_jal_d, is_jalr_d, take_d;
  logic [1:0]  wb_d;
  logic        br_eq, br_lt, br_ltu;
  logic        redirect;
  logic        unused_fields;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign unused_fields = ^{instr[24:15], instr[11:7], alu_result[0]};

  imm_gen u_imm_gen (
    .instr (instr),
    .imm   (imm)
  );

  assign br_eq  = (rs1_data == rs2_data);
  assign br_lt  = ($signed(rs1_data) < $signed(rs2_data));
  assign br_ltu = (rs1_data < rs2_data);

  // NOTE: every decoder output gets a default first so no path infers a latch.
  always_comb begin
    alu_op_d  = ALU_ADD;
    a_sel_d   = 1'b0;
    b_sel_d   = 1'b0;
    rw_d      = 1'b0;
    mr_d      = 1'b0;
    mw_d      = 1'b0;
    wb_d      = WB_ALU;
    is_jal_d  = 1'b0;
    is_jalr_d = 1'b0;
    take_d    = 1'b0;
    legal_d   = 1'b1;
    case (opcode)
      OP_R: begin
        if (funct7 == 7'h00 || (funct7 == 7'h20 && (funct3 == 3'd0 || funct3 == 3'd5))) begin
          rw_d     = 1'b1;
          alu_op_d = alu_from_funct(funct3, funct7[5], 1'b1);
        end else legal_d = 1'b0;
      end
      OP_IMM: begin
        if ((funct3 == 3'd1 && funct7 != 7'h00) ||
            (funct3 == 3'd5 && funct7 != 7'h00 && funct7 != 7'h20)) begin
          legal_d = 1'b0;
        end else begin
          rw_d     = 1'b1;
          b_sel_d  = 1'b1;
          alu_op_d = alu_from_funct(funct3, funct7[5], 1'b0);
        end
      end
      OP_LOAD: begin
        if (funct3 == 3'd2) begin
          rw_d    = 1'b1;
          mr_d    = 1'b1;
          b_sel_d = 1'b1;
          wb_d    = WB_MEM;
        end else legal_d = 1'b0;
      end
      OP_STORE: begin
        if (funct3 == 3'd2) begin
          mw_d    = 1'b1;
          b_sel_d = 1'b1;
        end else legal_d = 1'b0;
      end
      OP_BRANCH: begin
        case (funct3)
          3'd0:    take_d = br_eq;
          3'd1:    take_d = !br_eq;
          3'd4:    take_d = br_lt;
          3'd5:    take_d = !br_lt;
          3'd6:    take_d = br_ltu;
          3'd7:    take_d = !br_ltu;
          default: legal_d = 1'b0;
        endcase
      end
      OP_JAL: begin
        rw_d     = 1'b1;
        wb_d     = WB_PC4;
        is_jal_d = 1'b1;
      end
      OP_JALR: begin
        if (funct3 == 3'd0) begin
          rw_d      = 1'b1;
          b_sel_d   = 1'b1;
          wb_d      = WB_PC4;
          is_jalr_d = 1'b1;
        end else legal_d = 1'b0;
      end
      OP_LUI: begin
        rw_d     = 1'b1;
        b_sel_d  = 1'b1;
        alu_op_d = ALU_PASS_B;
      end
      OP_AUIPC: begin
        rw_d    = 1'b1;
        a_sel_d = 1'b1;
        b_sel_d = 1'b1;
      end
      default: legal_d = 1'b0;
    endcase
  end

  assign redirect = legal_d & (is_jal_d | is_jalr_d | take_d);
  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    pc_d = pc_plus4;
    if (is_jalr_d)                 pc_d = {alu_result[31:1], 1'b0};
    else if (is_jal_d || take_d)   pc_d = pc_q + imm;
`ifdef CU_ILLEGAL_EN
    if (!legal_d)                  pc_d = pc_q;
`endif
  end

  // NOTE: state updates use non-blocking assignments; the async reset loads RESET_PC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

`ifdef CU_ILLEGAL_EN
  assign illegal = ~legal_d;
`else
  assign illegal = 1'b0;
`endif

  // Side-effecting enables drop immediately while reset is held.
  assign pc           = pc_q;
  assign alu_op       = alu_op_d;
  assign alu_a_sel    = a_sel_d;
  assign alu_b_sel    = b_sel_d;
  assign wb_sel       = wb_d;
  assign reg_write    = rw_d & legal_d & ~reset;
  assign mem_read     = mr_d & legal_d & ~reset;
  assign mem_write    = mw_d & legal_d & ~reset;
  assign branch_taken = redirect & ~reset;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit; expected values are hand-computed from RV32I encodings.
module tb_control_unit;

  logic        clk, reset;
  logic [31:0] instr, rs1_data, rs2_data, alu_result;
  logic [31:0] pc, pc_plus4, imm;
  logic [3:0]  alu_op;
  logic        alu_a_sel, alu_b_sel, reg_write, mem_read, mem_write;
  logic [1:0]  wb_sel;
  logic        branch_taken, illegal;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] ADD   = 32'h0020_81B3;
  localparam logic [31:0] SUB   = 32'h4020_81B3;
  localparam logic [31:0] LW    = 32'h0080_A283;
  localparam logic [31:0] SW    = 32'hFE50_AE23;
  localparam logic [31:0] BEQ   = 32'h0020_8863;
  localparam logic [31:0] BLT   = 32'h0020_C863;
  localparam logic [31:0] BLTU  = 32'h0020_E863;
  localparam logic [31:0] JAL   = 32'h0080_00EF;
  localparam logic [31:0] JALR  = 32'h0001_00E7;
  localparam logic [31:0] LUI   = 32'h1234_52B7;
  localparam logic [31:0] AUIPC = 32'hFFFF_F297;
  localparam logic [31:0] SRAI  = 32'h4031_5093;
  localparam logic [31:0] ADDIN = 32'hC001_0093;
  localparam logic [31:0] BAD   = 32'h0000_007F;

  control_unit dut (
    .clk          (clk),
    .reset        (reset),
    .instr        (instr),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .alu_result   (alu_result),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .imm          (imm),
    .alu_op       (alu_op),
    .alu_a_sel    (alu_a_sel),
    .alu_b_sel    (alu_b_sel),
    .reg_write    (reg_write),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .wb_sel       (wb_sel),
    .branch_taken (branch_taken),
    .illegal      (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic [31:0] i);
    instr = i;
    #1;
  endtask

  initial begin
    reset = 1'b0; instr = ADD; rs1_data = '0; rs2_data = '0; alu_result = '0;
    #2 reset = 1'b1;
    #1;
    check("rst_pc", pc, 32'h0);
    check("rst_reg_write", {31'b0, reg_write}, 32'd0);
    tick(); tick();
    check("rst_pc_hold", pc, 32'h0);

    reset = 1'b0; instr = NOP;
    repeat (3) tick();
    check("nop_pc12", pc, 32'd12);

    apply(ADD);
    check("add_alu_op", {28'b0, alu_op}, 32'd0);
    check("add_b_sel", {31'b0, alu_b_sel}, 32'd0);
    check("add_reg_write", {31'b0, reg_write}, 32'd1);
    check("add_wb_sel", {30'b0, wb_sel}, 32'd0);
    apply(SUB);
    check("sub_alu_op", {28'b0, alu_op}, 32'd1);

    apply(LW);
    check("lw_imm", imm, 32'd8);
    check("lw_mem_read", {31'b0, mem_read}, 32'd1);
    check("lw_wb_sel", {30'b0, wb_sel}, 32'd1);
    apply(SW);
    check("sw_imm", imm, 32'hFFFF_FFFC);
    check("sw_mem_write", {31'b0, mem_write}, 32'd1);
    check("sw_reg_write", {31'b0, reg_write}, 32'd0);

    apply(SRAI);
    check("srai_alu_op", {28'b0, alu_op}, 32'd7);
    apply(ADDIN);
    check("addi_neg_alu_op", {28'b0, alu_op}, 32'd0);
    check("addi_neg_imm", imm, 32'hFFFF_FC00);
    apply(LUI);
    check("lui_alu_op", {28'b0, alu_op}, 32'd10);
    check("lui_imm", imm, 32'h1234_5000);
    apply(AUIPC);
    check("auipc_imm", imm, 32'hFFFF_F000);
    check("auipc_a_sel", {31'b0, alu_a_sel}, 32'd1);

    instr = NOP;
    repeat (5) tick();
    check("pc_0x20", pc, 32'h20);

    rs1_data = 32'd7; rs2_data = 32'd8;
    apply(BEQ);
    check("beq_ne_taken", {31'b0, branch_taken}, 32'd0);
    check("beq_imm", imm, 32'd16);
    rs2_data = 32'd7;
    #1;
    check("beq_eq_taken", {31'b0, branch_taken}, 32'd1);
    check("beq_reg_write", {31'b0, reg_write}, 32'd0);
    tick();
    check("beq_target", pc, 32'h30);

    rs2_data = 32'd8;
    apply(BEQ);
    tick();
    check("beq_fallthru", pc, 32'h34);

    rs1_data = 32'hFFFF_FFFF; rs2_data = 32'd1;
    apply(BLT);
    check("blt_taken", {31'b0, branch_taken}, 32'd1);
    apply(BLTU);
    check("bltu_taken", {31'b0, branch_taken}, 32'd0);
    instr = NOP;
    repeat (3) tick();
    check("pc_0x40", pc, 32'h40);

    apply(JAL);
    check("jal_wb_sel", {30'b0, wb_sel}, 32'd2);
    check("jal_pc_plus4", pc_plus4, 32'h44);
    check("jal_taken", {31'b0, branch_taken}, 32'd1);
    tick();
    check("jal_target", pc, 32'h48);

    alu_result = 32'h101;
    apply(JALR);
    check("jalr_b_sel", {31'b0, alu_b_sel}, 32'd1);
    check("jalr_taken", {31'b0, branch_taken}, 32'd1);
    tick();
    check("jalr_target", pc, 32'h100);

    apply(BAD);
    check("bad_reg_write", {31'b0, reg_write}, 32'd0);
`ifdef CU_ILLEGAL_EN
    check("bad_illegal", {31'b0, illegal}, 32'd1);
    tick();
    check("bad_pc_hold", pc, 32'h100);
`else
    check("bad_illegal", {31'b0, illegal}, 32'd0);
    tick();
    check("bad_pc_adv", pc, 32'h104);
`endif

    alu_result = 32'hFFFF_FFFC;
    apply(JALR);
    tick();
    check("wrap_pc", pc, 32'hFFFF_FFFC);
    apply(NOP);
    check("wrap_pc_plus4", pc_plus4, 32'h0);
    tick();
    check("wrap_pc0", pc, 32'h0);
    tick();

    apply(ADD);
    check("mid_pre_reg_write", {31'b0, reg_write}, 32'd1);
    reset = 1'b1;
    #1;
    check("mid_reg_write", {31'b0, reg_write}, 32'd0);
    check("mid_pc", pc, 32'h0);
    tick();
    check("mid_pc_hold", pc, 32'h0);
    reset = 1'b0;
    tick();
    check("post_rst_pc", pc, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
